// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the start-timeout counter width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  // One extra bit so the counter can hold START_TIMEOUT-1 for any timeout value.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first set request strictly after ptr_i,
// wrapping around, so the last winner has the lowest priority.
module rr_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic                     valid_o,
  output logic [$clog2(N_REQ)-1:0] idx_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand_s;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_s  = IDX_W'((int'(ptr_i) + k) % N_REQ);
      valid_o = valid_o | req_i[cand_s];
      idx_o   = req_i[cand_s] ? cand_s : idx_o;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte
// requesters, with send/busy sequencing, ack on frame completion and start timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          ack,
  output logic [N_REQ-1:0]          err,
  output logic [$clog2(N_REQ)-1:0]  grant_idx,
  output logic                      active,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_send,
  input  logic                      tx_busy
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int TIMER_W = timer_width(START_TIMEOUT);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               send_q, send_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   err_q, err_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Next-state logic; ack/err default low so each is a single-cycle pulse.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    send_d  = send_q;
    timer_d = timer_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          for (int i = 0; i < N_REQ; i++) begin
            data_d = (pick_idx == IDX_W'(i)) ? req_data[i*DATA_W +: DATA_W] : data_d;
          end
          send_d  = 1'b1;
          timer_d = '0;
          state_d = ST_SEND;
        end else begin
          send_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (tx_busy) begin
          send_d  = 1'b0;
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TIMER_W'(START_TIMEOUT - 1)) begin
          send_d         = 1'b0;
          err_d[grant_q] = 1'b1;
          ptr_d          = grant_q;
          state_d        = ST_IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        // Frame length belongs to the transmitter, so no timeout here.
        if (!tx_busy) begin
          ack_d[grant_q] = 1'b1;
          ptr_d          = grant_q;
          state_d        = ST_IDLE;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; ptr starts at N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      data_q  <= '0;
      send_q  <= 1'b0;
      timer_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      send_q  <= send_d;
      timer_q <= timer_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign grant_idx = grant_q;
  assign tx_data   = data_q;
  assign tx_send   = send_q;
  assign active    = (state_q != ST_IDLE);

endmodule
